// File: rtl/cpu_timer_pkg.sv
// Shared definitions for the CPU timer: register map, CTRL field positions,
// bus widths and a byte-lane merge helper.
package cpu_timer_pkg;

  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam int ADDR_W = 5;
  localparam int DIV_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_MTIME    = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_MTIMECMP = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 5'h10;
  localparam logic [ADDR_W-1:0] ADDR_RSVD     = 5'h18;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  // Register select taken from address bits [4:3] of a 64-bit aligned access.
  typedef enum logic [1:0] {
    SEL_MTIME    = 2'd0,
    SEL_MTIMECMP = 2'd1,
    SEL_CTRL     = 2'd2,
    SEL_RSVD     = 2'd3
  } reg_sel_e;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] result;
    result = old_val;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) result[8*i +: 8] = new_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/cpu_timer_prescaler.sv
// Programmable prescaler: counts 0..div while enabled and emits a tick on
// the wrap cycle; clr restarts the count and suppresses that cycle's tick.
module cpu_timer_prescaler
  import cpu_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = en && !clr && (count == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == div) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_timer.sv
// Memory-mapped 64-bit machine timer (MTIME/MTIMECMP/CTRL) with a
// one-cycle-latency request/response port and a registered compare interrupt.
module cpu_timer
  import cpu_timer_pkg::*;
#(
  parameter logic [DIV_W-1:0]  DIV_RESET = '0,
  parameter logic [DATA_W-1:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              time_irq_o
);

  logic [DATA_W-1:0] mtime, mtime_d;
  logic [DATA_W-1:0] mtimecmp, mtimecmp_d;
  logic [DATA_W-1:0] read_val;
  logic              en, en_d;
  logic [DIV_W-1:0]  div, div_d;
  logic              misaligned, wr, ctrl_wr, tick, irq;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  reg_sel_e          sel;

  assign req_ready_o = rst_ni;
  assign misaligned  = |req_addr_i[2:0];
  assign sel         = reg_sel_e'(req_addr_i[4:3]);
  assign wr          = req_valid_i && req_we_i && !misaligned;
  assign ctrl_wr     = wr && (sel == SEL_CTRL);

  cpu_timer_prescaler u_prescaler (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (en),
    .clr   (ctrl_wr),
    .div   (div),
    .tick  (tick)
  );

  always_comb begin
    read_val = '0;
    case (sel)
      SEL_MTIME:    read_val = mtime;
      SEL_MTIMECMP: read_val = mtimecmp;
      SEL_CTRL: begin
        read_val[CTRL_EN_BIT]              = en;
        read_val[CTRL_DIV_LSB +: DIV_W]    = div;
      end
      default:      read_val = '0;
    endcase
  end

  // A software write to MTIME takes priority over the tick increment.
  always_comb begin
    mtime_d    = mtime;
    mtimecmp_d = mtimecmp;
    en_d       = en;
    div_d      = div;
    if (wr && (sel == SEL_MTIME)) begin
      mtime_d = merge_bytes(mtime, req_wdata_i, req_be_i);
    end else if (tick) begin
      mtime_d = mtime + 64'd1;
    end
    if (wr && (sel == SEL_MTIMECMP)) begin
      mtimecmp_d = merge_bytes(mtimecmp, req_wdata_i, req_be_i);
    end
    if (ctrl_wr) begin
      if (req_be_i[CTRL_EN_BIT/8])  en_d  = req_wdata_i[CTRL_EN_BIT];
      if (req_be_i[CTRL_DIV_LSB/8]) div_d = req_wdata_i[CTRL_DIV_LSB +: DIV_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime     <= '0;
      mtimecmp  <= CMP_RESET;
      en        <= 1'b0;
      div       <= DIV_RESET;
      irq       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mtime     <= mtime_d;
      mtimecmp  <= mtimecmp_d;
      en        <= en_d;
      div       <= div_d;
      irq       <= (mtime >= mtimecmp);
      rsp_valid <= req_valid_i;
      rsp_err   <= req_valid_i && misaligned;
      rsp_rdata <= (req_valid_i && !req_we_i && !misaligned) ? read_val : '0;
    end
  end

  assign rsp_valid_o = rsp_valid;
  assign rsp_err_o   = rsp_err;
  assign rsp_rdata_o = rsp_rdata;
  assign time_irq_o  = irq;

endmodule

// File: tb/tb_cpu_timer.sv
// Directed bench for cpu_timer: a register-access vector table followed by
// hand-written sequences for prescaling, wrap, write-vs-tick, irq and reset.
module tb_cpu_timer;
  import cpu_timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        time_irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  cpu_timer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .time_irq_o  (time_irq)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One request held across a single rising edge; response is visible at return.
  task automatic applyStimulus(input logic we, input logic [4:0] addr,
                               input logic [63:0] wdata, input logic [7:0] be);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic accessCheck(input string name, input logic we, input logic [4:0] addr,
                             input logic [63:0] wdata, input logic [7:0] be,
                             input logic [63:0] exp_rdata, input logic exp_err);
    applyStimulus(we, addr, wdata, be);
    checkOutput({name, ".valid"}, 64'(rsp_valid), 64'd1);
    checkOutput({name, ".rdata"}, rsp_rdata, exp_rdata);
    checkOutput({name, ".err"},   64'(rsp_err), 64'(exp_err));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({name, ".rsp_rdata"}, rsp_rdata, 64'd0);
    checkOutput({name, ".rsp_err"},   64'(rsp_err), 64'd0);
    checkOutput({name, ".irq"},       64'(time_irq), 64'd0);
    checkOutput({name, ".ready"},     64'(req_ready), 64'd0);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Register-access table with the timer disabled, so values stay put.
    vecs[0]  = '{1'b0, 5'h08, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{1'b0, 5'h00, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[2]  = '{1'b0, 5'h10, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[3]  = '{1'b1, 5'h08, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0};
    vecs[4]  = '{1'b0, 5'h08, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0};
    vecs[5]  = '{1'b1, 5'h10, 64'hFFFF_FFFF_FFFF_FE00, 8'hFF, 64'h0, 1'b0};
    vecs[6]  = '{1'b0, 5'h10, 64'h0, 8'h00, 64'h0000_0000_0000_FE00, 1'b0};
    vecs[7]  = '{1'b0, 5'h04, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[8]  = '{1'b1, 5'h0C, 64'h0, 8'hFF, 64'h0, 1'b1};
    vecs[9]  = '{1'b0, 5'h08, 64'h0, 8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0};
    vecs[10] = '{1'b1, 5'h18, 64'hDEAD_BEEF, 8'hFF, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 5'h18, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[12] = '{1'b1, 5'h00, 64'h0000_0000_0000_AABB, 8'h02, 64'h0, 1'b0};
    vecs[13] = '{1'b0, 5'h00, 64'h0, 8'h00, 64'h0000_0000_0000_AA00, 1'b0};

    doReset();
    for (int i = 0; i < 14; i++) begin
      accessCheck($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    checkOutput("irq_idle", 64'(time_irq), 64'd0);

    // DIV=3: MTIME steps every 4 cycles; irq one cycle after MTIME reaches 10.
    doReset();
    applyStimulus(1'b1, ADDR_MTIMECMP, 64'd10, 8'hFF);
    applyStimulus(1'b1, ADDR_CTRL, 64'h0301, 8'hFF);
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(1'b0, ADDR_MTIME, 64'h0, 8'h00);
      checkOutput($sformatf("prescale_read%0d", n), rsp_rdata, 64'((n - 1) / 4));
    end
    idle(28);
    checkOutput("irq_before_match", 64'(time_irq), 64'd0);
    idle(1);
    checkOutput("irq_at_match", 64'(time_irq), 64'd1);
    applyStimulus(1'b1, ADDR_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    checkOutput("irq_cmp_raise_1", 64'(time_irq), 64'd1);
    idle(1);
    checkOutput("irq_cmp_raise_2", 64'(time_irq), 64'd0);

    // DIV=0 wrap of an all-ones MTIME.
    applyStimulus(1'b1, ADDR_CTRL, 64'h0, 8'hFF);
    applyStimulus(1'b1, ADDR_MTIME, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    applyStimulus(1'b1, ADDR_CTRL, 64'h0001, 8'hFF);
    accessCheck("wrap_pre", 1'b0, ADDR_MTIME, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    accessCheck("wrap_post", 1'b0, ADDR_MTIME, 64'h0, 8'h00, 64'h0, 1'b0);

    // Partial MTIME write in a tick cycle beats the increment.
    applyStimulus(1'b1, ADDR_CTRL, 64'h0, 8'hFF);
    applyStimulus(1'b1, ADDR_MTIME, 64'h1234_5678_9ABC_DEFF, 8'hFF);
    applyStimulus(1'b1, ADDR_CTRL, 64'h0001, 8'hFF);
    applyStimulus(1'b1, ADDR_MTIME, 64'h55, 8'h01);
    accessCheck("tick_write", 1'b0, ADDR_MTIME, 64'h0, 8'h00, 64'h1234_5678_9ABC_DE55, 1'b0);
    accessCheck("tick_write_next", 1'b0, ADDR_MTIME, 64'h0, 8'h00, 64'h1234_5678_9ABC_DE56, 1'b0);

    // Reset asserted right after a request is accepted: no response survives.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ADDR_MTIMECMP;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    checkOutput("no_phantom_rsp", 64'(rsp_valid), 64'd0);
    accessCheck("post_reset_cmp", 1'b0, ADDR_MTIMECMP, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    accessCheck("post_reset_mtime", 1'b0, ADDR_MTIME, 64'h0, 8'h00, 64'h0, 1'b0);
    accessCheck("post_reset_ctrl", 1'b0, ADDR_CTRL, 64'h0, 8'h00, 64'h0, 1'b0);
    checkOutput("post_reset_irq", 64'(time_irq), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_timer.md
CPU_TIMER -- requirements
Module: cpu_timer

Interface
REQ-001 SHALL have parameter DIV_RESET, default 0, reset value of CTRL.DIV.
REQ-002 SHALL have parameter CMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, reset value of MTIMECMP.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  register access request.
REQ-006 SHALL have port req_ready_o  output  1  request accepted.
REQ-007 SHALL have port req_we_i  input  1  1=write, 0=read.
REQ-008 SHALL have port req_addr_i  input  5  byte address, 64-bit aligned.
REQ-009 SHALL have port req_wdata_i  input  64  write data.
REQ-010 SHALL have port req_be_i  input  8  write byte enables.
REQ-011 SHALL have port rsp_valid_o  output  1  response valid.
REQ-012 SHALL have port rsp_rdata_o  output  64  read data.
REQ-013 SHALL have port rsp_err_o  output  1  access error.
REQ-014 SHALL have port time_irq_o  output  1  timer interrupt to the CPU subsystem time_irq_i, level.

Function
REQ-015 req_ready_o SHALL be 1 whenever not in reset; a request is accepted when req_valid_i=1.
REQ-016 Each accepted request SHALL produce exactly one response: rsp_valid_o=1 for one cycle, the cycle after acceptance; back-to-back requests give back-to-back responses.
REQ-017 Register map: 0x00 MTIME, 0x08 MTIMECMP, 0x10 CTRL (bit0 EN, bits[15:8] DIV, others read 0, write ignored), 0x18 reads 0, writes ignored, no error.
REQ-018 req_addr_i[2:0]!=0 SHALL give rsp_err_o=1, rdata=0, no state change; otherwise rsp_err_o=0.
REQ-019 Writes SHALL update only the bytes with req_be_i set; be=0 is a legal no-op.
REQ-020 Read data SHALL be the register value sampled in the acceptance cycle, before that cycle's update.
REQ-021 Prescaler: 8-bit counter; with EN=1 it counts 0..DIV then wraps to 0; a tick SHALL be generated on the wrap cycle; DIV=0 gives one tick per cycle.
REQ-022 MTIME SHALL increment by 1 on each tick, 64-bit modular (all-ones wraps to 0).
REQ-023 EN=0 SHALL freeze the prescaler and MTIME; a write to CTRL SHALL clear the prescaler.
REQ-024 A write to MTIME in a tick cycle SHALL win: the written bytes take the written value, unwritten bytes keep their pre-increment value, and no increment occurs that cycle.
REQ-025 time_irq_o SHALL be registered: it is 1 the cycle after MTIME>=MTIMECMP (unsigned) holds on the updated values, otherwise 0.
REQ-026 A MTIMECMP write raising the compare value above MTIME SHALL deassert time_irq_o 2 cycles after acceptance.

Reset
REQ-027 On rst_ni low: MTIME=0, MTIMECMP=CMP_RESET, EN=0, DIV=DIV_RESET, prescaler=0, time_irq_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=0.
REQ-028 A request accepted in the cycle before reset asserts SHALL get no response; after release, operation restarts from the reset state.

Structure
REQ-029 A shared package cpu_timer_pkg SHALL hold the register offsets, CTRL bit positions, and the 64-bit data and 8-bit enable widths.
REQ-030 The prescaler SHALL be the sub-module cpu_timer_prescaler (inputs en, clr, div; output tick).

Verification
REQ-031 Reset, then read 0x08 -> rdata=64'hFFFF_FFFF_FFFF_FFFF, err=0, time_irq_o=0.
REQ-032 CTRL=0x0301 (EN, DIV=3), MTIMECMP=10 -> MTIME increments every 4 cycles; time_irq_o rises one cycle after MTIME reaches 10.
REQ-033 MTIME=64'hFFFF_FFFF_FFFF_FFFF, DIV=0, EN=1 -> next cycle MTIME=0.
REQ-034 Write MTIME=0x55 with be=8'h01 in a tick cycle -> MTIME[7:0]=0x55, upper bytes unchanged, no increment.
REQ-035 Read 0x04 -> rsp_err_o=1, rdata=0, all registers unchanged.
REQ-036 With time_irq_o=1, write MTIMECMP=all-ones -> time_irq_o=0 two cycles after acceptance; rst_ni pulse mid-access -> no response, all outputs at reset values.
